// File: rtl/char_pkg.sv
// Shared key codes and vertical state encoding for the player-character controller.
package char_pkg;

    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_JUMP  = 8'd82;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } vstate_t;

endpackage

// File: rtl/char_vert_phys.sv
// Vertical motion of the character: jump launch, gravity, and ground/ceiling clamping.
module char_vert_phys
    import char_pkg::*;
#(
    parameter int unsigned W        = 10,
    parameter int unsigned Y_GROUND = 380,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned SIZE     = 12,
    parameter int unsigned JUMP_V   = 8,
    parameter int unsigned GRAVITY  = 1
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         jump_req,
    output logic [W-1:0] y,
    output logic         airborne
);

    localparam int unsigned SW = W + 2;
    localparam logic signed [SW-1:0] Y_GND_S = SW'(Y_GROUND);
    localparam logic signed [SW-1:0] Y_TOP_S = SW'(Y_MIN + SIZE);
    localparam logic signed [W:0]    VY_JUMP = (W+1)'(JUMP_V);
    localparam logic signed [W:0]    VY_GRAV = (W+1)'(GRAVITY);

    vstate_t               state, state_d;
    logic signed [W:0]     vy, vy_d;
    logic [W-1:0]          y_d;
    logic signed [SW-1:0]  ny;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= GROUND;
            vy       <= '0;
            y        <= W'(Y_GROUND);
            airborne <= 1'b0;
        end else begin
            state    <= state_d;
            vy       <= vy_d;
            y        <= y_d;
            airborne <= (state_d == AIR);
        end
    end

    // Next-state: vy is positive upward, so the candidate y moves opposite to vy.
    always_comb begin
        state_d = state;
        vy_d    = vy;
        y_d     = y;
        ny      = $signed({2'b00, y}) - SW'(vy);
        case (state)
            GROUND: begin
                if (jump_req) begin
                    state_d = AIR;
                    vy_d    = VY_JUMP;
                end
            end
            AIR: begin
                vy_d = vy - VY_GRAV;
                if (ny >= Y_GND_S) begin
                    y_d     = W'(Y_GROUND);
                    vy_d    = '0;
                    state_d = GROUND;
                end else if (ny < Y_TOP_S) begin
                    y_d  = W'(Y_MIN + SIZE);
                    vy_d = '0;
                end else begin
                    y_d = W'(ny);
                end
            end
            default: state_d = GROUND;
        endcase
    end

endmodule

// File: rtl/char_ctrl.sv
// Per-player character controller: clamped horizontal stepping, facing flag, jump physics.
// Optional per-turn horizontal step budget enabled by defining MOVE_BUDGET_EN.
module char_ctrl
    import char_pkg::*;
#(
    parameter int unsigned W           = 10,
    parameter int unsigned X_INIT      = 400,
    parameter int unsigned Y_GROUND    = 380,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned SIZE        = 12,
    parameter int unsigned X_STEP      = 1,
    parameter int unsigned JUMP_V      = 8,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned MOVE_BUDGET = 64
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         is_in_turn,
    input  logic [7:0]   keycode,
    output logic [W-1:0] ch_x,
    output logic [W-1:0] ch_y,
    output logic [W-1:0] ch_size_x,
    output logic [W-1:0] ch_size_y,
    output logic         facing_left,
    output logic         airborne,
    output logic [W-1:0] moves_left
);

    localparam logic [W:0] X_LO = (W+1)'(X_MIN + SIZE);
    localparam logic [W:0] X_HI = (W+1)'(X_MAX - SIZE);
    localparam logic [W:0] STEP = (W+1)'(X_STEP);

    logic         go_left, go_right, jump_req, step_ok;
    logic [W:0]   x_ext;
    logic [W-1:0] x_d;
    logic         facing_d;

    assign go_left   = is_in_turn && (keycode == KEY_LEFT);
    assign go_right  = is_in_turn && (keycode == KEY_RIGHT);
    assign jump_req  = is_in_turn && (keycode == KEY_JUMP);
    assign x_ext     = {1'b0, ch_x};
    assign ch_size_x = W'(SIZE);
    assign ch_size_y = W'(SIZE);

    // Clamp against the bounds in W+1 bits so neither edge can wrap.
    always_comb begin
        x_d      = ch_x;
        facing_d = facing_left;
        if (go_left) begin
            facing_d = 1'b1;
            if (step_ok)
                x_d = (x_ext < X_LO + STEP) ? W'(X_LO) : W'(x_ext - STEP);
        end else if (go_right) begin
            facing_d = 1'b0;
            if (step_ok)
                x_d = (x_ext + STEP > X_HI) ? W'(X_HI) : W'(x_ext + STEP);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            ch_x        <= W'(X_INIT);
            facing_left <= 1'b0;
        end else begin
            ch_x        <= x_d;
            facing_left <= facing_d;
        end
    end

`ifdef MOVE_BUDGET_EN
    logic turn_q;

    assign step_ok = (moves_left != '0);

    // Budget reloads when a turn starts; reload wins over a same-frame step.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            turn_q     <= 1'b0;
            moves_left <= W'(MOVE_BUDGET);
        end else begin
            turn_q <= is_in_turn;
            if (is_in_turn && !turn_q)
                moves_left <= W'(MOVE_BUDGET);
            else if ((go_left || go_right) && step_ok)
                moves_left <= moves_left - W'(1);
        end
    end
`else
    assign step_ok    = 1'b1;
    assign moves_left = '0;
`endif

    char_vert_phys #(
        .W        (W),
        .Y_GROUND (Y_GROUND),
        .Y_MIN    (Y_MIN),
        .SIZE     (SIZE),
        .JUMP_V   (JUMP_V),
        .GRAVITY  (GRAVITY)
    ) u_vert (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .jump_req  (jump_req),
        .y         (ch_y),
        .airborne  (airborne)
    );

endmodule

// File: tb/tb_char_ctrl.sv
// Randomized and directed bench for char_ctrl against a frame-level behavioural model.
module tb_char_ctrl;

    localparam int N  = 3;
    localparam int SZ = 12;
    localparam int MB = 3;
    localparam int XI [N] = '{400, 20, 400};
    localparam int YG [N] = '{380, 380, 30};
`ifdef MOVE_BUDGET_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       is_in_turn;
    logic [7:0] keycode;

    logic [9:0] x_o [N];
    logic [9:0] y_o [N];
    logic [9:0] sx_o[N];
    logic [9:0] sy_o[N];
    logic [9:0] mv_o[N];
    logic       face_o[N];
    logic       air_o [N];

    always #5 frame_clk = ~frame_clk;

    char_ctrl #(.X_INIT(400), .Y_GROUND(380), .MOVE_BUDGET(MB)) dut0 (
        .frame_clk(frame_clk), .Reset(Reset), .is_in_turn(is_in_turn), .keycode(keycode),
        .ch_x(x_o[0]), .ch_y(y_o[0]), .ch_size_x(sx_o[0]), .ch_size_y(sy_o[0]),
        .facing_left(face_o[0]), .airborne(air_o[0]), .moves_left(mv_o[0]));

    char_ctrl #(.X_INIT(20), .Y_GROUND(380), .MOVE_BUDGET(MB)) dut1 (
        .frame_clk(frame_clk), .Reset(Reset), .is_in_turn(is_in_turn), .keycode(keycode),
        .ch_x(x_o[1]), .ch_y(y_o[1]), .ch_size_x(sx_o[1]), .ch_size_y(sy_o[1]),
        .facing_left(face_o[1]), .airborne(air_o[1]), .moves_left(mv_o[1]));

    char_ctrl #(.X_INIT(400), .Y_GROUND(30), .MOVE_BUDGET(MB)) dut2 (
        .frame_clk(frame_clk), .Reset(Reset), .is_in_turn(is_in_turn), .keycode(keycode),
        .ch_x(x_o[2]), .ch_y(y_o[2]), .ch_size_x(sx_o[2]), .ch_size_y(sy_o[2]),
        .facing_left(face_o[2]), .airborne(air_o[2]), .moves_left(mv_o[2]));

    typedef struct {
        int x; int y; int vy; bit air; bit face; int moves; bit turn_q;
    } mdl_t;

    mdl_t m[N];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input int k);
        mdl_t r;
        r.x = XI[k]; r.y = YG[k]; r.vy = 0; r.air = 1'b0; r.face = 1'b0;
        r.moves = BEN ? MB : 0; r.turn_q = 1'b0;
        return r;
    endfunction

    // One frame of the character's rules, in plain integer arithmetic.
    function automatic mdl_t mdl_step(input mdl_t c, input int k, input bit turn, input int key);
        mdl_t n = c;
        bit   moved = 1'b0;
        bit   may = !BEN || (c.moves > 0);
        int   ny;
        if (turn && key == 80) begin
            n.face = 1'b1;
            if (may) begin n.x = (c.x - 1 < SZ) ? SZ : c.x - 1; moved = 1'b1; end
        end else if (turn && key == 79) begin
            n.face = 1'b0;
            if (may) begin n.x = (c.x + 1 > 639 - SZ) ? 639 - SZ : c.x + 1; moved = 1'b1; end
        end
        if (BEN) begin
            if (turn && !c.turn_q) n.moves = MB;
            else if (moved)        n.moves = c.moves - 1;
        end
        n.turn_q = turn;
        if (!c.air) begin
            if (turn && key == 82) begin n.air = 1'b1; n.vy = 8; end
        end else begin
            ny   = c.y - c.vy;
            n.vy = c.vy - 1;
            if (ny >= YG[k])  begin n.y = YG[k]; n.vy = 0; n.air = 1'b0; end
            else if (ny < SZ) begin n.y = SZ;    n.vy = 0; end
            else                    n.y = ny;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        for (int k = 0; k < N; k++)
            m[k] = Reset ? mdl_reset(k) : mdl_step(m[k], k, is_in_turn, int'(keycode));
        #1;
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("x%0d", k),    int'(x_o[k]),    m[k].x);
            check_eq($sformatf("y%0d", k),    int'(y_o[k]),    m[k].y);
            check_eq($sformatf("air%0d", k),  int'(air_o[k]),  int'(m[k].air));
            check_eq($sformatf("face%0d", k), int'(face_o[k]), int'(m[k].face));
            check_eq($sformatf("moves%0d", k), int'(mv_o[k]),  m[k].moves);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; is_in_turn = 1'b0; keycode = 8'd0;
        tick();
        Reset = 1'b0;
    endtask

    int  exp_y [17] = '{372, 365, 359, 354, 350, 347, 345, 344, 344,
                        345, 347, 350, 354, 359, 365, 372, 380};
    bit  landed;
    int  r;

    initial begin
        do_reset();
        check_eq("rst_x",    int'(x_o[0]),   400);
        check_eq("rst_y",    int'(y_o[0]),   380);
        check_eq("rst_air",  int'(air_o[0]), 0);
        check_eq("rst_face", int'(face_o[0]), 0);
        check_eq("rst_mv",   int'(mv_o[0]),  BEN ? MB : 0);
        check_eq("size_x",   int'(sx_o[0]),  12);
        check_eq("size_y",   int'(sy_o[0]),  12);

        // Walk right five frames
        is_in_turn = 1'b1; keycode = 8'd79;
        repeat (5) tick();
`ifndef MOVE_BUDGET_EN
        check_eq("walk_x", int'(x_o[0]), 405);
`endif
        check_eq("walk_face", int'(face_o[0]), 0);
        check_eq("walk_y",    int'(y_o[0]),    380);

        // Left edge clamp from X_INIT=20
        do_reset();
        is_in_turn = 1'b1; keycode = 8'd80;
        repeat (20) tick();
`ifndef MOVE_BUDGET_EN
        check_eq("left_clamp_x", int'(x_o[1]), 12);
`endif
        check_eq("left_face", int'(face_o[1]), 1);

        // Jump arc
        do_reset();
        is_in_turn = 1'b1; keycode = 8'd82;
        tick();
        check_eq("jump_start_air", int'(air_o[0]), 1);
        check_eq("jump_start_y",   int'(y_o[0]),   380);
        keycode = 8'd0;
        for (int i = 0; i < 17; i++) begin
            tick();
            check_eq($sformatf("arc_y[%0d]", i),   int'(y_o[0]),   exp_y[i]);
            check_eq($sformatf("arc_air[%0d]", i), int'(air_o[0]), (i < 16) ? 1 : 0);
        end

        // Turn lost mid-jump while holding right
        do_reset();
        is_in_turn = 1'b1; keycode = 8'd82;
        tick();
        keycode = 8'd79;
        repeat (2) tick();
        is_in_turn = 1'b0;
        repeat (15) tick();
`ifndef MOVE_BUDGET_EN
        check_eq("frozen_x", int'(x_o[0]), 402);
`endif
        check_eq("fall_y",   int'(y_o[0]),   380);
        check_eq("fall_air", int'(air_o[0]), 0);

        // Ceiling hit with Y_GROUND=30
        do_reset();
        is_in_turn = 1'b1; keycode = 8'd82;
        tick();
        keycode = 8'd0;
        repeat (3) tick();
        check_eq("ceil_y", int'(y_o[2]), 12);
        landed = 1'b0;
        for (int i = 0; i < 40 && !landed; i++) begin
            tick();
            if (!air_o[2]) landed = 1'b1;
        end
        check_eq("ceil_landed", int'(landed), 1);
        check_eq("ceil_land_y", int'(y_o[2]), 30);

`ifdef MOVE_BUDGET_EN
        // Budget exhaustion and reload on a new turn
        do_reset();
        is_in_turn = 1'b1; keycode = 8'd0;
        tick();
        keycode = 8'd79;
        repeat (6) tick();
        check_eq("budget_x",  int'(x_o[0]),  403);
        check_eq("budget_mv", int'(mv_o[0]), 0);
        is_in_turn = 1'b0; keycode = 8'd0;
        tick();
        is_in_turn = 1'b1;
        tick();
        check_eq("reload_mv", int'(mv_o[0]), MB);
`endif

        // Randomized frames
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Reset      = ($urandom_range(0, 99) < 2);
            is_in_turn = ($urandom_range(0, 7) != 0);
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: keycode = 8'd79;
                3, 4, 5: keycode = 8'd80;
                6:       keycode = 8'd82;
                7:       keycode = 8'd0;
                default: keycode = 8'($urandom_range(0, 255));
            endcase
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/char_ctrl.md
Name: char_ctrl

Overview:
Parametrised player-character controller, next generation of the turn-based tank/character mover.
- Adds jump with gravity, edge clamping instead of bounce, and a facing flag.
- Sits between the keycode decoder and the sprite/collision logic; one instance per player, gated by the turn arbiter's is_in_turn.
- All state updates once per frame_clk edge (one frame).

Parameters:
W, 10, coordinate/velocity width (bits)
X_INIT, 400, x position after reset
Y_GROUND, 380, ground y (centre of character when standing)
X_MIN, 0, left screen bound
X_MAX, 639, right screen bound
Y_MIN, 0, top screen bound
SIZE, 12, half-size of character (driven on ch_size_x/ch_size_y)
X_STEP, 1, horizontal pixels per frame
JUMP_V, 8, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity decrement per frame
MOVE_BUDGET, 64, horizontal steps per turn (only with MOVE_BUDGET_EN)

Ports:
frame_clk  in  1  clock, one edge per frame
Reset  in  1  synchronous active-high reset
is_in_turn  in  1  player may act this frame
keycode  in  8  current key; 80=left, 79=right, 82=jump
ch_x  out  W  character centre x
ch_y  out  W  character centre y
ch_size_x  out  W  constant SIZE
ch_size_y  out  W  constant SIZE
facing_left  out  1  last horizontal direction pressed
airborne  out  1  high while in state AIR
moves_left  out  W  remaining horizontal budget (tied 0 without MOVE_BUDGET_EN)

Behaviour:
- Clock and reset: one clock, frame_clk. Reset is synchronous and active-high.
- Reset values: ch_x=X_INIT, ch_y=Y_GROUND, vy=0, state=GROUND, facing_left=0, airborne=0, moves_left=MOVE_BUDGET (or 0 when the feature is compiled out).
- Latency: keycode sampled at edge N; position reflects it after edge N (registered, 1 frame).
- Horizontal, only when is_in_turn=1 (allowed in both states):
  - keycode 80: x <= max(x-X_STEP, X_MIN+SIZE); facing_left <= 1.
  - keycode 79: x <= min(x+X_STEP, X_MAX-SIZE); facing_left <= 0.
  - Any other key: x holds.
  - Compute in W+1 bits; no wrap-around at either bound.
- Vertical FSM, states GROUND and AIR; vy is signed W+1 bits, positive = up.
  - GROUND: if is_in_turn and keycode==82, go to AIR with vy<=JUMP_V. y is unchanged that frame. Otherwise hold.
  - AIR, every frame regardless of is_in_turn:
    - ny = y - vy; vy <= vy - GRAVITY.
    - If ny >= Y_GROUND: y<=Y_GROUND, vy<=0, go to GROUND (landing).
    - Else if ny < Y_MIN+SIZE: y<=Y_MIN+SIZE, vy<=0 (ceiling hit, then falls).
    - Else y<=ny.
  - Jump key while in AIR is ignored (no double jump).
- Turn lost mid-jump: horizontal motion freezes, the fall completes, and the character lands.
- Simultaneous keys are impossible (single keycode). Jump plus movement needs alternating keycodes.
- Reset mid-jump: immediate return to reset values on the next edge.
- airborne = (state==AIR), registered.

Optional Feature:
MOVE_BUDGET_EN
- Defined:
  - W-bit counter reloads to MOVE_BUDGET on a rising edge of is_in_turn (registered previous value).
  - Decrements on each accepted horizontal step. At 0, left/right keys are ignored; facing_left still updates.
  - Reload takes priority over decrement in the same frame.
  - Jumps do not consume budget.
- Undefined: unlimited movement; moves_left tied to 0.

Decomposition:
- Package char_pkg:
  - KEY_LEFT=8'd80, KEY_RIGHT=8'd79, KEY_JUMP=8'd82.
  - typedef enum {GROUND, AIR} vstate_t.
- Sub-module char_vert_phys: vertical FSM, vy, y, ceiling/ground clamp. Its inputs are jump_req and frame_clk/Reset; its outputs are y and airborne.
- Horizontal clamp and budget stay in char_ctrl.

Test Plan:
1. Reset, then is_in_turn=1, keycode=79 for 5 frames -> ch_x=405, facing_left=0; ch_y=380 throughout.
2. X_INIT=20, keycode=80 for 20 frames -> ch_x decreases to 12 and holds at 12 (no wrap, no bounce).
3. keycode=82 for one frame, then 0 -> airborne=1; y sequence 372,365,359,354,350,347,345,344,344,345,… Lands at 380 with airborne=0 after exactly 17 AIR frames.
4. Jump, then drop is_in_turn on frame 3 while holding 79 -> x frozen from that frame; y completes the arc to 380.
5. Y_GROUND=30, SIZE=12, jump -> y clamps at 12, vy=0, then falls back to 30.
6. MOVE_BUDGET_EN, MOVE_BUDGET=3: turn starts, hold 79 for 6 frames -> x advances 3, moves_left=0. Toggle is_in_turn 0→1 -> moves_left=3.
